// File: rtl/jk_seq_ctrl_pkg.sv
// Shared encodings for the JK bank sequencer: opcodes, FSM states and opcode helpers.
package jk_seq_ctrl_pkg;

    localparam logic [2:0] OP_HOLD   = 3'd0;
    localparam logic [2:0] OP_CLEAR  = 3'd1;
    localparam logic [2:0] OP_LOAD   = 3'd2;
    localparam logic [2:0] OP_INVERT = 3'd3;
    localparam logic [2:0] OP_UP     = 3'd4;
    localparam logic [2:0] OP_DOWN   = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Opcodes 6 and 7 are reserved: they execute as HOLD and raise err.
    function automatic logic is_reserved(input logic [2:0] op);
        return op > OP_DOWN;
    endfunction

    function automatic logic is_count(input logic [2:0] op);
        return (op == OP_UP) || (op == OP_DOWN);
    endfunction

endpackage

// File: rtl/jk_seq_ctrl_cell.sv
// Single JK flip-flop cell with asynchronous active-low clear; qnot is always ~q.
module jk_ff_cell (
    input  logic clk,
    input  logic reset,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qnot
);

    logic q_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q <= 1'b0;
        end else begin
            case ({j, k})
                2'b01:   q_q <= 1'b0;
                2'b10:   q_q <= 1'b1;
                2'b11:   q_q <= ~q_q;
                default: q_q <= q_q;
            endcase
        end
    end

    assign q    = q_q;
    assign qnot = ~q_q;

endmodule

// File: rtl/jk_seq_ctrl.sv
// Command sequencer driving a bank of WIDTH JK cells (hold/clear/load/invert/count).
// Optional abort input/aborted output enabled by defining JK_SEQ_ABORT_EN.
module jk_seq_ctrl
    import jk_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [LEN_W-1:0] cmd_len,
`ifdef JK_SEQ_ABORT_EN
    input  logic             abort,
    output logic             aborted,
`endif
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qnot,
    output logic             busy,
    output logic             done,
    output logic             wrap,
    output logic             err
);

    state_e           state_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] data_q;
    logic [LEN_W-1:0] cnt_q;
    logic             done_q;
    logic             wrap_q;
    logic             err_q;

    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             exec;
    logic             abort_now;
    logic             last_step;
    logic             step_wrap;

    assign exec = (state_q == ST_EXEC);

`ifdef JK_SEQ_ABORT_EN
    logic aborted_q;
    assign abort_now = exec & abort;
    assign aborted   = aborted_q;
`else
    assign abort_now = 1'b0;
`endif

    assign last_step = !is_count(op_q) || (cnt_q == '0) || abort_now;
    assign step_wrap = exec && (((op_q == OP_UP) && (&q)) || ((op_q == OP_DOWN) && !(|q)));

    // Ripple toggle enables: cell i toggles when all lower cells are 1 (up) or 0 (down).
    always_comb begin
        logic up_c;
        logic dn_c;
        j    = '0;
        k    = '0;
        up_c = 1'b1;
        dn_c = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            if (exec) begin
                case (op_q)
                    OP_CLEAR:  k[i] = 1'b1;
                    OP_LOAD:   begin j[i] = data_q[i]; k[i] = ~data_q[i]; end
                    OP_INVERT: begin j[i] = data_q[i]; k[i] = data_q[i];  end
                    OP_UP:     begin j[i] = up_c;      k[i] = up_c;       end
                    OP_DOWN:   begin j[i] = dn_c;      k[i] = dn_c;       end
                    default:   ;
                endcase
            end
            up_c = up_c & q[i];
            dn_c = dn_c & qnot[i];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_HOLD;
            data_q    <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            wrap_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef JK_SEQ_ABORT_EN
            aborted_q <= 1'b0;
`endif
        end else begin
            done_q    <= 1'b0;
            wrap_q    <= 1'b0;
`ifdef JK_SEQ_ABORT_EN
            aborted_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_q    <= cmd_op;
                        data_q  <= cmd_data;
                        cnt_q   <= cmd_len;
                        err_q   <= is_reserved(cmd_op);
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    wrap_q <= step_wrap;
                    if (last_step) begin
                        state_q   <= ST_DONE;
                        done_q    <= 1'b1;
`ifdef JK_SEQ_ABORT_EN
                        aborted_q <= abort_now;
`endif
                    end else begin
                        cnt_q <= cnt_q - LEN_W'(1);
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = !cmd_ready;
    assign done      = done_q;
    assign wrap      = wrap_q;
    assign err       = err_q;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        jk_ff_cell u_cell (
            .clk  (clk),
            .reset(reset),
            .j    (j[gi]),
            .k    (k[gi]),
            .q    (q[gi]),
            .qnot (qnot[gi])
        );
    end

endmodule

// File: tb/tb_jk_seq_ctrl.sv
// Bench for jk_seq_ctrl: command table with per-cycle scoreboard plus hand-written corner sequences.
module tb_jk_seq_ctrl;
    import jk_seq_ctrl_pkg::*;

    localparam int W  = 4;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_op = 3'd0;
    logic [W-1:0]  cmd_data = '0;
    logic [LW-1:0] cmd_len = '0;
    logic [W-1:0]  q;
    logic [W-1:0]  qnot;
    logic          busy, done, wrap, err;
`ifdef JK_SEQ_ABORT_EN
    logic          abort = 1'b0;
    logic          aborted;
`endif

    always #5 clk = ~clk;

    jk_seq_ctrl #(.WIDTH(W), .LEN_W(LW)) dut (
        .clk      (clk),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_data (cmd_data),
        .cmd_len  (cmd_len),
`ifdef JK_SEQ_ABORT_EN
        .abort    (abort),
        .aborted  (aborted),
`endif
        .q        (q),
        .qnot     (qnot),
        .busy     (busy),
        .done     (done),
        .wrap     (wrap),
        .err      (err)
    );

    typedef struct packed {
        logic [W-1:0] q;
        logic         busy;
        logic         done;
        logic         wrap;
        logic         err;
        logic         ready;
    } exp_t;

    typedef struct {
        logic [2:0]    op;
        logic [W-1:0]  data;
        logic [LW-1:0] len;
        logic [W-1:0]  q_fin;
        logic          err_fin;
        int            wraps;
    } vec_t;

    exp_t         sb[$];
    vec_t         tbl[15];
    int           checks = 0;
    int           failures = 0;
    int           wraps_seen = 0;
    logic [W-1:0] mq = '0;
    logic         merr = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    // Pops one expected cycle per falling edge while a command is in flight.
    always @(negedge clk) begin
        exp_t e;
        if (wrap === 1'b1) wraps_seen++;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("cycle q/qnot/busy/done/wrap/err/ready",
                {q, qnot, busy, done, wrap, err, cmd_ready},
                {e.q, ~e.q, e.busy, e.done, e.wrap, e.err, e.ready});
        end
    end

    task automatic wait_ready();
        int g = 0;
        while (cmd_ready !== 1'b1 && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (cmd_ready !== 1'b1) chk("ready_timeout", {31'd0, cmd_ready}, 32'd1);
    endtask

    task automatic run_cmd(input logic [2:0] op, input logic [W-1:0] data, input logic [LW-1:0] len);
        int   n;
        int   g;
        logic mw;
        @(negedge clk);
        wait_ready();
        cmd_op    = op;
        cmd_data  = data;
        cmd_len   = len;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        merr = (op == 3'd6) || (op == 3'd7);
        n    = ((op == OP_UP) || (op == OP_DOWN)) ? int'(len) + 1 : 1;
        mw   = 1'b0;
        for (int s = 0; s < n; s++) begin
            sb.push_back('{q: mq, busy: 1'b1, done: 1'b0, wrap: mw, err: merr, ready: 1'b0});
            mw = 1'b0;
            case (op)
                OP_CLEAR:  mq = '0;
                OP_LOAD:   mq = data;
                OP_INVERT: mq = mq ^ data;
                OP_UP:     begin mw = (mq == '1); mq = mq + W'(1); end
                OP_DOWN:   begin mw = (mq == '0); mq = mq - W'(1); end
                default:   ;
            endcase
        end
        sb.push_back('{q: mq, busy: 1'b1, done: 1'b1, wrap: mw, err: merr, ready: 1'b0});
        sb.push_back('{q: mq, busy: 1'b0, done: 1'b0, wrap: 1'b0, err: merr, ready: 1'b1});
        g = 0;
        while (sb.size() > 0 && g < 100) begin
            @(posedge clk);
            g++;
        end
        chk("drain_timeout", sb.size(), 32'd0);
        sb.delete();
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{OP_LOAD,   4'b1010, 4'd0,  4'b1010, 1'b0, 0};
        tbl[1]  = '{OP_INVERT, 4'b0110, 4'd0,  4'b1100, 1'b0, 0};
        tbl[2]  = '{OP_CLEAR,  4'b1111, 4'd0,  4'b0000, 1'b0, 0};
        tbl[3]  = '{OP_LOAD,   4'b1110, 4'd0,  4'b1110, 1'b0, 0};
        tbl[4]  = '{OP_UP,     4'b0000, 4'd3,  4'b0010, 1'b0, 1};
        tbl[5]  = '{OP_LOAD,   4'b0001, 4'd0,  4'b0001, 1'b0, 0};
        tbl[6]  = '{OP_DOWN,   4'b0000, 4'd1,  4'b1111, 1'b0, 1};
        tbl[7]  = '{3'd7,      4'b1010, 4'd0,  4'b1111, 1'b1, 0};
        tbl[8]  = '{OP_LOAD,   4'b0101, 4'd0,  4'b0101, 1'b0, 0};
        tbl[9]  = '{OP_HOLD,   4'b1111, 4'd0,  4'b0101, 1'b0, 0};
        tbl[10] = '{3'd6,      4'b1111, 4'd5,  4'b0101, 1'b1, 0};
        tbl[11] = '{OP_DOWN,   4'b0000, 4'd0,  4'b0100, 1'b0, 0};
        tbl[12] = '{OP_UP,     4'b0000, 4'd15, 4'b0100, 1'b0, 1};
        tbl[13] = '{OP_DOWN,   4'b0000, 4'd15, 4'b0100, 1'b0, 1};
        tbl[14] = '{OP_INVERT, 4'b1111, 4'd0,  4'b1011, 1'b0, 0};

        // Reset state, and commands ignored while reset is low.
        cmd_op = OP_LOAD; cmd_data = 4'b1111; cmd_valid = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_state", {q, qnot, busy, cmd_ready, done, wrap, err},
            {4'h0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        cmd_valid = 1'b0;
        reset = 1'b1;

        // Asynchronous reset in the middle of a long UP count.
        @(negedge clk);
        cmd_op = OP_UP; cmd_len = 4'd7; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midup_q", {28'd0, q}, 32'h1);
        #2 reset = 1'b0;
        #1 chk("async_reset", {q, qnot, busy, cmd_ready, done, wrap, err},
               {4'h0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("no_done_after_reset", {31'd0, done}, 32'd0);
        end
        chk("ready_after_reset", {q, cmd_ready, busy}, {4'h0, 1'b1, 1'b0});
        mq = '0; merr = 1'b0;

        for (int i = 0; i < 15; i++) begin
            wraps_seen = 0;
            run_cmd(tbl[i].op, tbl[i].data, tbl[i].len);
            chk($sformatf("vec%0d_q", i),     {28'd0, q},   {28'd0, tbl[i].q_fin});
            chk($sformatf("vec%0d_err", i),   {31'd0, err}, {31'd0, tbl[i].err_fin});
            chk($sformatf("vec%0d_wraps", i), wraps_seen,   tbl[i].wraps);
        end

        // cmd_valid held through busy: the second command waits for the IDLE cycle after done.
        @(negedge clk);
        wait_ready();
        cmd_op = OP_LOAD; cmd_data = 4'b0011; cmd_len = 4'd0; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_data = 4'b1100;
        @(negedge clk);
        chk("hold_exec1", {busy, cmd_ready, q}, {1'b1, 1'b0, 4'b1011});
        @(negedge clk);
        chk("hold_done1", {done, busy, q}, {1'b1, 1'b1, 4'b0011});
        @(negedge clk);
        chk("hold_idle", {cmd_ready, busy, done, q}, {1'b1, 1'b0, 1'b0, 4'b0011});
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk("hold_exec2", {busy, q}, {1'b1, 4'b0011});
        @(negedge clk);
        chk("hold_done2", {done, q}, {1'b1, 4'b1100});
        @(negedge clk);
        mq = 4'b1100;

`ifdef JK_SEQ_ABORT_EN
        // Abort on the second EXEC cycle of a 10-step count: exactly two steps taken.
        wait_ready();
        cmd_op = OP_UP; cmd_len = 4'd9; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_exec2", {busy, q}, {1'b1, 4'b1101});
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_done", {done, aborted, q}, {1'b1, 1'b1, 4'b1110});
        @(negedge clk);
        chk("abort_idle", {aborted, busy, q}, {1'b0, 1'b0, 4'b1110});
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
